// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : Instruction-memory read bus between the fetch unit and imem.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_stall;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_stall,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_stall,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Program counter, imem fetch address and IF/ID register with
//            bubble insertion on boot, redirect and misaligned-target fault.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int                   PC_WIDTH     = 32,
    parameter int                   INST_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = 32'h00000000,
    parameter logic [INST_WIDTH-1:0] NOP_INST    = 32'h00000033
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    inst_fetch_unit_if.master     imem,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  if_valid,
    output logic                  fault,
    output logic [PC_WIDTH-1:0]   fault_pc
);

    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FAULT = 2'd2;

    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);

    logic [1:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                w_misaligned;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // Address comes straight from the PC register, so it only changes on posedge.
    assign imem.imem_addr  = r_pc;
    assign imem.imem_stall = (r_state == c_ST_RUN)   ? stall :
                             (r_state == c_ST_FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_BOOT;
            r_pc     <= RESET_VECTOR;
            if_pc    <= '0;
            if_inst  <= NOP_INST;
            if_valid <= 1'b0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    // Memory output is meaningless for the first cycle after reset.
                    if_inst  <= NOP_INST;
                    if_valid <= 1'b0;
                    r_state  <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (redirect_valid) begin
                        if_inst  <= NOP_INST;
                        if_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_state  <= c_ST_FAULT;
                            fault    <= 1'b1;
                            fault_pc <= redirect_pc;
                        end else begin
                            r_pc  <= redirect_pc;
                            if_pc <= redirect_pc;
                        end
                    end else if (!stall) begin
                        if_inst  <= imem.imem_rdata;
                        if_pc    <= r_pc;
                        if_valid <= 1'b1;
                        r_pc     <= r_pc + c_PC_STEP;
                    end
                end
                c_ST_FAULT: begin
                    // Sticky until reset: stall and redirect are ignored here.
                    if_inst  <= NOP_INST;
                    if_valid <= 1'b0;
                end
                default: begin
                    r_state  <= c_ST_FAULT;
                    fault    <= 1'b1;
                    if_inst  <= NOP_INST;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Directed checks of inst_fetch_unit, including a wrap instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h00000033;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;

    logic [31:0] if_pc,   if_pc2;
    logic [31:0] if_inst, if_inst2;
    logic        if_valid, if_valid2;
    logic        fault,   fault2;
    logic [31:0] fault_pc, fault_pc2;

    int n_cmp;
    int n_err;

    inst_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus0 ();
    inst_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus1 ();

    inst_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus0),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    inst_fetch_unit #(.RESET_VECTOR(32'hFFFFFFF8)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .stall          (stall2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .imem           (bus1),
        .if_pc          (if_pc2),
        .if_inst        (if_inst2),
        .if_valid       (if_valid2),
        .fault          (fault2),
        .fault_pc       (fault_pc2)
    );

    // Two programmed words; every other address returns addr ^ 0xA5A50000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00500093;
        else if (a == 32'h4) return 32'h00100113;
        else                 return a ^ 32'hA5A50000;
    endfunction

    assign bus0.imem_rdata = mem_word(bus0.imem_addr);
    assign bus1.imem_rdata = mem_word(bus1.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; rst2 = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;

        step(); step();
        chk("rst_addr",     bus0.imem_addr, 32'h0);
        chk("rst_valid",    32'(if_valid), 32'h0);
        chk("rst_inst",     if_inst, c_NOP);
        chk("rst_if_pc",    if_pc, 32'h0);
        chk("rst_fault",    32'(fault), 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_istall",   32'(bus0.imem_stall), 32'h0);
        chk("rst2_addr",    bus1.imem_addr, 32'hFFFFFFF8);

        rst = 1'b1; rst2 = 1'b1;
        step();
        chk("boot_valid",  32'(if_valid), 32'h0);
        chk("boot_inst",   if_inst, c_NOP);
        chk("boot_addr",   bus0.imem_addr, 32'h0);
        chk("boot2_addr",  bus1.imem_addr, 32'hFFFFFFF8);
        step();
        chk("f0_valid", 32'(if_valid), 32'h1);
        chk("f0_pc",    if_pc, 32'h0);
        chk("f0_inst",  if_inst, 32'h00500093);
        chk("f0_addr",  bus0.imem_addr, 32'h4);
        chk("w0_pc",    if_pc2, 32'hFFFFFFF8);
        chk("w0_inst",  if_inst2, 32'h5A5AFFF8);
        chk("w0_addr",  bus1.imem_addr, 32'hFFFFFFFC);
        step();
        chk("f1_pc",    if_pc, 32'h4);
        chk("f1_inst",  if_inst, 32'h00100113);
        chk("f1_addr",  bus0.imem_addr, 32'h8);
        chk("w1_pc",    if_pc2, 32'hFFFFFFFC);
        chk("w1_addr",  bus1.imem_addr, 32'h0);
        step();
        chk("f2_pc",    if_pc, 32'h8);
        chk("f2_inst",  if_inst, 32'hA5A50008);
        chk("f2_addr",  bus0.imem_addr, 32'hC);
        chk("w2_pc",    if_pc2, 32'h0);
        chk("w2_inst",  if_inst2, 32'h00500093);
        chk("w2_valid", 32'(if_valid2), 32'h1);
        chk("w2_fault", 32'(fault2), 32'h0);

        // Stall for three cycles.
        stall = 1'b1;
        #1;
        chk("stall_istall_now", 32'(bus0.imem_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",     if_pc, 32'h8);
            chk("stall_inst",   if_inst, 32'hA5A50008);
            chk("stall_addr",   bus0.imem_addr, 32'hC);
            chk("stall_istall", 32'(bus0.imem_stall), 32'h1);
            chk("stall_valid",  32'(if_valid), 32'h1);
        end
        stall = 1'b0;
        step();
        chk("resume_pc",   if_pc, 32'hC);
        chk("resume_inst", if_inst, 32'hA5A5000C);
        chk("resume_addr", bus0.imem_addr, 32'h10);

        // Aligned redirect from pc 0x10 to 0x40.
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(if_valid), 32'h0);
        chk("redir_inst",  if_inst, c_NOP);
        chk("redir_addr",  bus0.imem_addr, 32'h40);
        chk("redir_if_pc", if_pc, 32'h40);
        step();
        chk("tgt_pc",    if_pc, 32'h40);
        chk("tgt_valid", 32'(if_valid), 32'h1);
        chk("tgt_inst",  if_inst, 32'hA5A50040);
        chk("tgt_addr",  bus0.imem_addr, 32'h44);

        // Redirect and stall together: redirect wins.
        redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("rs_addr",  bus0.imem_addr, 32'h80);
        chk("rs_valid", 32'(if_valid), 32'h0);
        chk("rs_inst",  if_inst, c_NOP);
        step();
        chk("rs_tgt_pc",   if_pc, 32'h80);
        chk("rs_tgt_inst", if_inst, 32'hA5A50080);
        chk("rs_tgt_addr", bus0.imem_addr, 32'h84);

        // Misaligned redirect enters sticky fault.
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        chk("mis_fault",    32'(fault), 32'h1);
        chk("mis_fault_pc", fault_pc, 32'h42);
        chk("mis_valid",    32'(if_valid), 32'h0);
        chk("mis_inst",     if_inst, c_NOP);
        chk("mis_istall",   32'(bus0.imem_stall), 32'h1);
        chk("mis_addr",     bus0.imem_addr, 32'h84);
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("flt_ignore_addr", bus0.imem_addr, 32'h84);
        chk("flt_fault",       32'(fault), 32'h1);
        chk("flt_fault_pc",    fault_pc, 32'h42);
        step();
        chk("flt_valid",       32'(if_valid), 32'h0);
        chk("flt_istall",      32'(bus0.imem_stall), 32'h1);

        // Asynchronous reset mid-cycle clears the fault at once.
        rst = 1'b0;
        #2;
        chk("arst_fault",    32'(fault), 32'h0);
        chk("arst_fault_pc", fault_pc, 32'h0);
        chk("arst_addr",     bus0.imem_addr, 32'h0);
        chk("arst_valid",    32'(if_valid), 32'h0);
        rst = 1'b1;
        step();
        chk("reboot_valid", 32'(if_valid), 32'h0);
        chk("reboot_addr",  bus0.imem_addr, 32'h0);
        step();
        chk("reboot_pc",    if_pc, 32'h0);
        chk("reboot_inst",  if_inst, 32'h00500093);
        chk("reboot_fault", 32'(fault), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the program counter and drives the word-aligned fetch address.
- Captures the returned instruction into the IF/ID register and inserts bubbles (NOP 0x00000033) on boot, redirect and fault.
- Sits between the hazard/branch logic (stall, redirect) and the instruction memory, which samples the address on negedge and returns data before the next posedge.

Parameters:
PC_WIDTH, 32, width of PC and addresses
INST_WIDTH, 32, instruction width
RESET_VECTOR, 32'h00000000, first fetch address after reset
NOP_INST, 32'h00000033, bubble encoding (add x0,x0,x0)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous reset, active-low
stall  input  1  hazard stall; hold PC and IF/ID contents
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  PC_WIDTH  redirect target
imem_rdata  input  INST_WIDTH  instruction for the current imem_addr
imem_addr  output  PC_WIDTH  fetch address (= pc_q)
imem_stall  output  1  hold request to memory (= stall in RUN, 1 in FAULT, else 0)
if_pc  output  PC_WIDTH  PC of if_inst
if_inst  output  INST_WIDTH  fetched instruction to decode
if_valid  output  1  if_inst is a real instruction
fault  output  1  misaligned redirect seen; sticky
fault_pc  output  PC_WIDTH  offending redirect target

Behaviour:
- Reset (rst=0, async): pc_q=RESET_VECTOR, if_pc=0, if_inst=NOP_INST, if_valid=0, fault=0, fault_pc=0, state=BOOT.
- FSM states: BOOT, RUN, FAULT.
- BOOT: lasts exactly one posedge after rst rises. pc_q holds, if_inst=NOP_INST, if_valid=0, then state goes to RUN. Reason: memory output is not valid during reset.
- RUN priority order per posedge: redirect > stall > normal.
- Redirect, target aligned (redirect_pc[1:0]==0): pc_q<=redirect_pc, if_inst<=NOP_INST, if_valid<=0, if_pc<=redirect_pc. The wrong-path word in flight is discarded. The redirect wins even when stall=1.
- Redirect, target misaligned: state<=FAULT, fault<=1, fault_pc<=redirect_pc, if_inst<=NOP_INST, if_valid<=0, pc_q holds.
- Stall (no redirect): pc_q, if_pc, if_inst and if_valid all hold. imem_stall=1 in the same cycle.
- Normal: if_inst<=imem_rdata, if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+4.
- Latency: address issued in cycle N appears on if_inst/if_pc from cycle N+1. Steady state is one instruction per cycle.
- Sequential redirect penalty: exactly one bubble (if_valid=0 for one cycle), then the target instruction in the next cycle.
- PC arithmetic is modulo 2^PC_WIDTH: pc_q=0xFFFFFFFC advances to 0x00000000 with no flag. pc_q[1:0] is always 00.
- FAULT: sticky until reset. Outputs NOP_INST with if_valid=0, imem_stall=1, and ignores stall and redirect.
- Reset mid-operation: returns immediately to reset values regardless of state. After release, BOOT then RUN from RESET_VECTOR.
- imem_addr is a combinational copy of pc_q and never glitches between posedges.

Test Plan:
- Boot: release rst, memory holds 0x00500093 @0, 0x00100113 @4. Required: one bubble, then if_pc=0/if_inst=0x00500093, then if_pc=4/if_inst=0x00100113, imem_addr advancing 0,4,8.
- Stall: stall=1 for 3 cycles with if_pc=8. Required: if_pc=8, if_inst and imem_addr=0xC held for 3 cycles, imem_stall=1. Fetch resumes at 0xC on release.
- Redirect: redirect_valid=1, redirect_pc=0x40 while pc_q=0x10. Required: next cycle if_valid=0/if_inst=0x00000033, imem_addr=0x40; following cycle if_pc=0x40, if_valid=1.
- Redirect+stall same cycle: redirect_pc=0x80, stall=1. Required: redirect taken, imem_addr=0x80, one bubble.
- Misaligned: redirect_pc=0x42. Required: fault=1, fault_pc=0x42, if_valid=0 permanently, later redirects ignored. Asserting rst clears fault and boot restarts at 0.
- Wrap: RESET_VECTOR=0xFFFFFFF8. Required: fetches at 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000, with no fault.
